mandel_job_scheduler: RTL

Multi-core frame scheduler for the Mandelbrot renderer. Walks the screen in raster order and hands one pixel job per cycle to NCORES escape-time iteration cores. Collects their iteration counts through a round-robin arbiter and maps each count to a colour. Drives the single VGA adapter plot port, replacing the one-core sequencer when more than one iteration core is instantiated.

---
 rtl/mandel_job_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mandel_job_scheduler.sv
// Frame scheduler: raster-order job dispatch to NCORES iteration cores,
// round-robin result collection and count-to-colour mapping onto one plot port.
module mandel_job_scheduler #(
  parameter int NCORES  = 2,
  parameter int WIDTH   = 160,
  parameter int HEIGHT  = 120,
  parameter int XW      = 8,
  parameter int YW      = 7,
  parameter int NW      = 8,
  parameter int MAXITER = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NCORES-1:0]    core_ready,
  output logic [NCORES-1:0]    job_valid,
  output logic [XW-1:0]        job_x,
  output logic [YW-1:0]        job_y,
  input  logic [NCORES-1:0]    res_valid,
  input  logic [NCORES*NW-1:0] res_n,
  input  logic [NCORES*XW-1:0] res_x,
  input  logic [NCORES*YW-1:0] res_y,
  output logic [NCORES-1:0]    res_ack,
  output logic                 plot,
  output logic [XW-1:0]        x,
  output logic [YW-1:0]        y,
  output logic [2:0]           colour,
  output logic                 busy,
  output logic                 done
);

  localparam int OW = $clog2(NCORES + 1);
  localparam int GW = (NCORES > 1) ? $clog2(NCORES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state, state_nx;
  logic [OW-1:0]   outstanding;
  logic [GW-1:0]   last_grant, grant_idx;
  logic            dispatch, grant, last_pixel;
  logic            jv_found, rr_found;
  int unsigned     rr_idx;
  logic [NW-1:0]   g_n;
  logic [XW-1:0]   g_x;
  logic [YW-1:0]   g_y;
  logic [2:0]      g_colour;

  always_comb begin
    job_valid = '0;
    jv_found  = 1'b0;
    if (state == RUN) begin
      for (int unsigned k = 0; k < NCORES; k++) begin
        if (core_ready[k] && !jv_found) begin
          job_valid[k] = 1'b1;
          jv_found     = 1'b1;
        end
      end
    end
  end

  assign dispatch   = |job_valid;
  assign last_pixel = (job_x == XW'(WIDTH - 1)) && (job_y == YW'(HEIGHT - 1));

  // Round-robin search begins one past the previous winner.
  always_comb begin
    res_ack   = '0;
    rr_found  = 1'b0;
    rr_idx    = 0;
    grant_idx = last_grant;
    if (state == RUN || state == DRAIN) begin
      for (int unsigned i = 1; i <= NCORES; i++) begin
        rr_idx = (32'(last_grant) + i) % NCORES;
        if (res_valid[rr_idx] && !rr_found) begin
          res_ack[rr_idx] = 1'b1;
          grant_idx       = GW'(rr_idx);
          rr_found        = 1'b1;
        end
      end
    end
  end

  assign grant = rr_found;

  always_comb begin
    g_n = res_n[int'(grant_idx)*NW +: NW];
    g_x = res_x[int'(grant_idx)*XW +: XW];
    g_y = res_y[int'(grant_idx)*YW +: YW];
    if (g_n == NW'(MAXITER))
      g_colour = 3'b000;
    else if (g_n[2:0] == 3'b000)
      g_colour = 3'b111;
    else
      g_colour = g_n[2:0];
  end

  // DRAIN exits on the edge where the final plot pulse leaves the register,
  // so done rises in the cycle right after that pulse.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (dispatch && last_pixel) state_nx = DRAIN;
      DRAIN:   if (outstanding == '0 && !grant) state_nx = DONE;
      DONE:    if (!start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      outstanding <= '0;
      last_grant  <= GW'(NCORES - 1);
      job_x       <= '0;
      job_y       <= '0;
      plot        <= 1'b0;
      x           <= '0;
      y           <= '0;
      colour      <= '0;
    end else begin
      state <= state_nx;

      if (dispatch && !grant)
        outstanding <= outstanding + OW'(1);
      else if (!dispatch && grant)
        outstanding <= outstanding - OW'(1);

      if (state == IDLE && start) begin
        job_x <= '0;
        job_y <= '0;
      end else if (dispatch) begin
        if (job_x == XW'(WIDTH - 1)) begin
          job_x <= '0;
          job_y <= last_pixel ? '0 : job_y + YW'(1);
        end else begin
          job_x <= job_x + XW'(1);
        end
      end

      if (grant) last_grant <= grant_idx;

      plot <= grant;
      if (grant) begin
        x      <= g_x;
        y      <= g_y;
        colour <= g_colour;
      end
    end
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

endmodule
